// File: rtl/sequenciador_programa.sv
// Instruction-fetch sequencer: drives the ROM address, latches the ROM word and issues it with a 1-cycle valid strobe.
// Optional breakpoint ports (i_bp_en, i_bp_addr) are enabled by defining SEQ_BREAKPOINT_EN.
module sequenciador_programa #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int ADDR_W  = 4,
    parameter int DEB_CYC = 1_000_000
) (
    input  logic              i_clk_50,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic              i_step_btn,
    input  logic [17:0]       i_rom_data,
`ifdef SEQ_BREAKPOINT_EN
    input  logic              i_bp_en,
    input  logic [ADDR_W-1:0] i_bp_addr,
`endif
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic [17:0]       o_instr,
    output logic              o_instr_valid,
    output logic              o_halted,
    output logic              o_pc_wrap
);

    // state  | meaning
    // S_IDLE | stopped; a debounced step issues one instruction
    // S_RUN  | one issue per divider tick
    // S_HALT | halt word fetched; waits for run to drop
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    localparam int DIV_TC = CLK_HZ / TICK_HZ - 1;
    localparam int DIV_W  = (DIV_TC > 0) ? $clog2(DIV_TC + 1) : 1;
    localparam int DEB_TC = (DEB_CYC > 1) ? DEB_CYC - 1 : 0;
    localparam int DEB_W  = (DEB_TC > 0) ? $clog2(DEB_TC + 1) : 1;
    localparam logic [DIV_W-1:0]  DIV_TC_V  = DIV_W'(DIV_TC);
    localparam logic [DEB_W-1:0]  DEB_TC_V  = DEB_W'(DEB_TC);
    localparam logic [17:0]       HALT_WORD = 18'h3FFFF;
    localparam logic [ADDR_W-1:0] PC_MAX    = '1;

    state_t             r_state;
    state_t             w_state_nx;
    logic               r_run_meta, r_run_s;
    logic               r_step_meta, r_step_s;
    logic               r_step_db;
    logic [DEB_W-1:0]   r_deb_cnt;
    logic [DIV_W-1:0]   r_div;
    logic [ADDR_W-1:0]  r_pc;
    logic [17:0]        r_instr;
    logic               r_instr_valid;
    logic               r_pc_wrap;

    logic               w_step_diff;
    logic               w_deb_tc;
    logic               w_step_p;
    logic               w_tick;
    logic               w_halt_word;
    logic               w_bp_hit;
    logic               w_issue;
    logic               w_pc_clr;

    always_ff @(posedge i_clk_50 or posedge i_rst) begin
        if (i_rst) begin
            r_run_meta  <= 1'b0;
            r_run_s     <= 1'b0;
            r_step_meta <= 1'b0;
            r_step_s    <= 1'b0;
        end else begin
            r_run_meta  <= i_run;
            r_run_s     <= r_run_meta;
            r_step_meta <= i_step_btn;
            r_step_s    <= r_step_meta;
        end
    end

    // The counter tracks consecutive samples that disagree with the accepted level.
    assign w_step_diff = (r_step_s != r_step_db);
    assign w_deb_tc    = (r_deb_cnt == DEB_TC_V);
    assign w_step_p    = w_step_diff && w_deb_tc && r_step_s;

    always_ff @(posedge i_clk_50 or posedge i_rst) begin
        if (i_rst) begin
            r_deb_cnt <= '0;
            r_step_db <= 1'b0;
        end else if (!w_step_diff) begin
            r_deb_cnt <= '0;
        end else if (w_deb_tc) begin
            r_deb_cnt <= '0;
            r_step_db <= r_step_s;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    assign w_tick = (r_state == S_RUN) && (r_div == DIV_TC_V);

    always_ff @(posedge i_clk_50 or posedge i_rst) begin
        if (i_rst) begin
            r_div <= '0;
        end else if ((r_state != S_RUN) || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_halt_word = (i_rom_data == HALT_WORD);

`ifdef SEQ_BREAKPOINT_EN
    assign w_bp_hit = i_bp_en && (r_pc == i_bp_addr);
`else
    assign w_bp_hit = 1'b0;
`endif

    always_ff @(posedge i_clk_50 or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_step_p && w_halt_word) begin
                    w_state_nx = S_HALT;
                end else if (r_run_s) begin
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                // Stop beats a coincident tick; breakpoint beats the halt word.
                if (!r_run_s) begin
                    w_state_nx = S_IDLE;
                end else if (w_tick && w_bp_hit) begin
                    w_state_nx = S_IDLE;
                end else if (w_tick && w_halt_word) begin
                    w_state_nx = S_HALT;
                end
            end
            S_HALT: begin
                if (!r_run_s) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_issue  = 1'b0;
        w_pc_clr = 1'b0;
        case (r_state)
            S_IDLE:  w_issue  = w_step_p && !w_halt_word;
            S_RUN:   w_issue  = r_run_s && w_tick && !w_bp_hit && !w_halt_word;
            S_HALT:  w_pc_clr = !r_run_s;
            default: w_issue  = 1'b0;
        endcase
        o_halted = (r_state == S_HALT);
    end

    always_ff @(posedge i_clk_50 or posedge i_rst) begin
        if (i_rst) begin
            r_pc          <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_pc_wrap     <= 1'b0;
        end else begin
            r_instr_valid <= w_issue;
            r_pc_wrap     <= w_issue && (r_pc == PC_MAX);
            if (w_issue) begin
                r_instr <= i_rom_data;
                r_pc    <= r_pc + 1'b1;
            end else if (w_pc_clr) begin
                r_pc <= '0;
            end
        end
    end

    assign o_rom_addr    = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_pc_wrap     = r_pc_wrap;

endmodule
